// File: rtl/data_mem_ctrl.sv
// Wait-stated data memory controller: byte/half/word little-endian accesses with a Stall/Done handshake.
// Optional request error checking (misalignment, conflicting codes, out-of-range) is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  MemRead_i,
   input  logic [1:0]  MemWrite_i,
   input  logic [31:0] Addr_i,
   input  logic [31:0] WriteData_i,
   output logic [31:0] ReadData_o,
   output logic        Stall_o,
   output logic        Done_o,
   output logic        Err_o
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state, next_state;
   logic [3:0]  count;
   logic [1:0]  rd_q, wr_q;
   logic [31:0] addr_q, wdata_q;
   logic        request, enter_done, commit, err_c;
   logic [1:0]  rd_c, wr_c, size;
   logic [31:0] addr_c, wdata_c;
   logic [29:0] word_addr, wrap_addr;
   logic [IW-1:0] idx;
   logic [3:0]  mask;
   logic [31:0] wshift, word_rd, rd_shift, rdata;
   logic        unused_wrap_bits;

   logic [31:0] mem [DEPTH_WORDS];

   assign request = (state == IDLE) && ((MemRead_i != 2'd0) || (MemWrite_i != 2'd0));
   assign Stall_o = request || (state == WAIT);
   assign Done_o  = (state == DONE);

   // In IDLE the live request drives the access so a zero-wait request can complete on its first edge.
   assign rd_c    = (state == IDLE) ? MemRead_i   : rd_q;
   assign wr_c    = (state == IDLE) ? MemWrite_i  : wr_q;
   assign addr_c  = (state == IDLE) ? Addr_i      : addr_q;
   assign wdata_c = (state == IDLE) ? WriteData_i : wdata_q;

   assign size             = (wr_c != 2'd0) ? wr_c : rd_c;
   assign word_addr        = addr_c[31:2];
   assign wrap_addr        = word_addr % 30'(DEPTH_WORDS);
   assign idx              = wrap_addr[IW-1:0];
   assign unused_wrap_bits = ^wrap_addr;
   assign word_rd          = mem[idx];

`ifdef DMEM_ERR_CHECK_EN
   logic err_q;

   assign err_c = ((size == 2'd2) && addr_c[0]) ||
                  ((size == 2'd3) && (addr_c[1:0] != 2'd0)) ||
                  ((rd_c != 2'd0) && (wr_c != 2'd0)) ||
                  (word_addr >= 30'(DEPTH_WORDS));
   assign Err_o = (state == DONE) && err_q;
`else
   assign err_c = 1'b0;
   assign Err_o = 1'b0;
`endif

   // Lane mask, positioned write data and right-justified read data; misaligned addresses align down.
   always_comb begin
      mask     = 4'b0000;
      wshift   = 32'd0;
      rd_shift = 32'd0;
      rdata    = 32'd0;
      case (size)
         2'd1: begin
            mask     = 4'b0001 << addr_c[1:0];
            wshift   = {24'd0, wdata_c[7:0]} << {addr_c[1:0], 3'b000};
            rd_shift = word_rd >> {addr_c[1:0], 3'b000};
            rdata    = {24'd0, rd_shift[7:0]};
         end
         2'd2: begin
            mask     = addr_c[1] ? 4'b1100 : 4'b0011;
            wshift   = {16'd0, wdata_c[15:0]} << {addr_c[1], 4'b0000};
            rd_shift = word_rd >> {addr_c[1], 4'b0000};
            rdata    = {16'd0, rd_shift[15:0]};
         end
         2'd3: begin
            mask  = 4'b1111;
            wshift = wdata_c;
            rdata = word_rd;
         end
         default: ;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (request) next_state = ((WAIT_CYCLES == 0) || err_c) ? DONE : WAIT;
         WAIT:    if (count <= 4'd1) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign enter_done = (next_state == DONE) && (state != DONE);
   assign commit     = enter_done && !err_c && (wr_c != 2'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         count      <= 4'd0;
         rd_q       <= 2'd0;
         wr_q       <= 2'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         ReadData_o <= 32'd0;
`ifdef DMEM_ERR_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state <= next_state;
         if (request) begin
            rd_q    <= MemRead_i;
            wr_q    <= MemWrite_i;
            addr_q  <= Addr_i;
            wdata_q <= WriteData_i;
            count   <= 4'(WAIT_CYCLES);
`ifdef DMEM_ERR_CHECK_EN
            err_q   <= err_c;
`endif
         end else if ((state == WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
         end
         if (enter_done)
            ReadData_o <= (!err_c && (wr_c == 2'd0) && (rd_c != 2'd0)) ? rdata : 32'd0;
      end
   end

   // Storage has no reset; the rst_i gate drops a write that would land on a reset edge.
   always_ff @(posedge clk_i) begin
      if (commit && !rst_i) begin
         for (int b = 0; b < 4; b++)
            if (mask[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (WAIT_CYCLES=2, DEPTH_WORDS=256).
// Expected values are hand-computed from the little-endian lane layout.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mem_read = 2'd0;
   logic [1:0]  mem_write = 2'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        stall, done, err;

   int checks = 0;
   int passes = 0;

   int          stall_cnt;
   int          done_seen;
   logic [31:0] rdata_seen;
   logic        err_seen;

   data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst), .MemRead_i(mem_read), .MemWrite_i(mem_write),
      .Addr_i(addr), .WriteData_i(write_data), .ReadData_o(read_data),
      .Stall_o(stall), .Done_o(done), .Err_o(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      else
         passes++;
   endtask

   // Drives one request from a negedge and samples once per cycle until Done_o; optionally keeps codes through the DONE edge.
   task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                                input logic [31:0] d, input bit hold_in_done);
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; write_data = d;
      stall_cnt = 0; done_seen = 0; rdata_seen = 32'hx; err_seen = 1'bx;
      for (int c = 0; c < 40 && done_seen == 0; c++) begin
         #1;
         if (stall) stall_cnt++;
         if (done) begin
            done_seen  = 1;
            rdata_seen = read_data;
            err_seen   = err;
         end else begin
            @(negedge clk);
         end
      end
      if (hold_in_done && done_seen != 0) begin
         @(posedge clk);
         #1;
      end
      mem_read = 2'd0; mem_write = 2'd0;
      checkOutput("done_within_budget", 32'(done_seen), 32'd1);
   endtask

   initial begin
      #1;
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);
      checkOutput("reset_rdata", read_data, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      applyStimulus(2'd0, 2'd3, 32'h10, 32'hDEADBEEF, 1'b0);
      checkOutput("wr_word_stall", 32'(stall_cnt), 32'd3);
      checkOutput("wr_word_rdata", rdata_seen, 32'd0);
      checkOutput("wr_word_err", {31'd0, err_seen}, 32'd0);

      applyStimulus(2'd3, 2'd0, 32'h10, 32'h0, 1'b0);
      checkOutput("rd_word_stall", 32'(stall_cnt), 32'd3);
      checkOutput("rd_word_data", rdata_seen, 32'hDEADBEEF);
      checkOutput("rd_word_err", {31'd0, err_seen}, 32'd0);

      applyStimulus(2'd0, 2'd1, 32'h13, 32'h000000AA, 1'b0);
      checkOutput("wr_byte_stall", 32'(stall_cnt), 32'd3);
      applyStimulus(2'd3, 2'd0, 32'h10, 32'h0, 1'b0);
      checkOutput("rd_word_after_byte", rdata_seen, 32'hAAADBEEF);
      applyStimulus(2'd2, 2'd0, 32'h12, 32'h0, 1'b0);
      checkOutput("rd_half_hi", rdata_seen, 32'h0000AAAD);
      applyStimulus(2'd2, 2'd0, 32'h10, 32'h0, 1'b0);
      checkOutput("rd_half_lo", rdata_seen, 32'h0000BEEF);
      applyStimulus(2'd1, 2'd0, 32'h11, 32'h0, 1'b0);
      checkOutput("rd_byte_1", rdata_seen, 32'h000000BE);
      applyStimulus(2'd1, 2'd0, 32'h13, 32'h0, 1'b0);
      checkOutput("rd_byte_3", rdata_seen, 32'h000000AA);

      // Half write into the upper lanes of another word, then readback.
      applyStimulus(2'd0, 2'd3, 32'h30, 32'h11223344, 1'b0);
      applyStimulus(2'd0, 2'd2, 32'h32, 32'hFFFF5566, 1'b0);
      applyStimulus(2'd3, 2'd0, 32'h30, 32'h0, 1'b0);
      checkOutput("rd_after_half_wr", rdata_seen, 32'h55663344);

`ifdef DMEM_ERR_CHECK_EN
      applyStimulus(2'd3, 2'd0, 32'h12, 32'h0, 1'b0);
      checkOutput("misaligned_stall", 32'(stall_cnt), 32'd1);
      checkOutput("misaligned_err", {31'd0, err_seen}, 32'd1);
      checkOutput("misaligned_rdata", rdata_seen, 32'd0);
      applyStimulus(2'd3, 2'd1, 32'h10, 32'h00000011, 1'b0);
      checkOutput("both_codes_err", {31'd0, err_seen}, 32'd1);
      applyStimulus(2'd3, 2'd0, 32'h410, 32'h0, 1'b0);
      checkOutput("out_of_range_err", {31'd0, err_seen}, 32'd1);
      applyStimulus(2'd3, 2'd0, 32'h10, 32'h0, 1'b0);
      checkOutput("mem_unchanged", rdata_seen, 32'hAAADBEEF);
`else
      applyStimulus(2'd3, 2'd0, 32'h12, 32'h0, 1'b0);
      checkOutput("misaligned_stall", 32'(stall_cnt), 32'd3);
      checkOutput("misaligned_aligned_down", rdata_seen, 32'hAAADBEEF);
      checkOutput("misaligned_err", {31'd0, err_seen}, 32'd0);
      applyStimulus(2'd3, 2'd0, 32'h410, 32'h0, 1'b0);
      checkOutput("index_wrap", rdata_seen, 32'hAAADBEEF);
      applyStimulus(2'd3, 2'd1, 32'h10, 32'h00000011, 1'b0);
      checkOutput("write_priority_rdata", rdata_seen, 32'd0);
      applyStimulus(2'd3, 2'd0, 32'h10, 32'h0, 1'b0);
      checkOutput("write_priority_mem", rdata_seen, 32'hAAADBE11);
`endif

      // Write pending in WAIT is discarded by an asynchronous reset.
      applyStimulus(2'd0, 2'd3, 32'h20, 32'hCAFEF00D, 1'b0);
      applyStimulus(2'd3, 2'd0, 32'h20, 32'h0, 1'b0);
      checkOutput("prior_value", rdata_seen, 32'hCAFEF00D);
      @(negedge clk);
      mem_write = 2'd3; addr = 32'h20; write_data = 32'h12345678;
      @(posedge clk);
      #3;
      checkOutput("in_wait_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1; mem_write = 2'd0;
      #1;
      checkOutput("async_rst_stall", {31'd0, stall}, 32'd0);
      checkOutput("async_rst_done", {31'd0, done}, 32'd0);
      checkOutput("async_rst_rdata", read_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'd3, 2'd0, 32'h20, 32'h0, 1'b0);
      checkOutput("write_discarded", rdata_seen, 32'hCAFEF00D);

      // Codes held through DONE are not re-accepted; then an idle stretch.
      applyStimulus(2'd1, 2'd0, 32'h22, 32'h0, 1'b1);
      checkOutput("held_read_data", rdata_seen, 32'h000000FE);
      begin
         int extra_done = 0;
         int extra_stall = 0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (done) extra_done++;
            if (stall) extra_stall++;
         end
         checkOutput("no_reaccept_done", 32'(extra_done), 32'd0);
         checkOutput("idle_stall", 32'(extra_stall), 32'd0);
      end
      checkOutput("rdata_held_idle", read_data, 32'h000000FE);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states per access, legal range 0..15.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port MemRead_i  input  2  read access code: 0 none, 1 byte, 2 half word, 3 word.
REQ-006 SHALL have port MemWrite_i  input  2  write access code, same encoding as MemRead_i.
REQ-007 SHALL have port Addr_i  input  32  byte address.
REQ-008 SHALL have port WriteData_i  input  32  write data, right-justified for byte and half-word accesses.
REQ-009 SHALL have port ReadData_o  output  32  read data, zero-extended, right-justified.
REQ-010 SHALL have port Stall_o  output  1  pipeline hold while an access is pending.
REQ-011 SHALL have port Done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port Err_o  output  1  error flag, qualified by Done_o.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 A request SHALL be any cycle in IDLE with MemRead_i != 0 or MemWrite_i != 0.
REQ-015 On a request, the FSM SHALL latch codes, address and data, load the counter with WAIT_CYCLES, and go to WAIT, or to DONE if WAIT_CYCLES = 0 or the request is in error.
REQ-016 WAIT SHALL decrement the counter each cycle and move to DONE when it reaches 1.
REQ-017 DONE SHALL last exactly one cycle, assert Done_o, ignore all inputs, and return to IDLE.
REQ-018 Stall_o SHALL be combinational: 1 when in IDLE with a request, 1 throughout WAIT, and 0 in DONE.
REQ-019 A non-error request SHALL hold Stall_o high for exactly 1+WAIT_CYCLES cycles; an error request SHALL hold it for 1 cycle.
REQ-020 A write SHALL commit on the edge entering DONE, updating only the addressed byte lanes; bytes SHALL be little-endian, byte Addr[1:0] occupying bits 8*Addr[1:0]+7 : 8*Addr[1:0].
REQ-021 ReadData_o SHALL be registered, valid only in DONE, holding its value until the next DONE, and SHALL be 0 for writes and errors.
REQ-022 A byte read SHALL return {24'b0, byte}; a half-word read SHALL return {16'b0, half}.
REQ-023 The word index SHALL be Addr[31:2]; no access SHALL occur to memory outside the latched address.
REQ-024 In IDLE with no request, all outputs except ReadData_o SHALL be 0.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, counter 0, ReadData_o 0, Done_o 0 and Err_o 0, with Stall_o following the combinational rule.
REQ-026 Storage contents SHALL NOT be reset.
REQ-027 A write pending when reset asserts SHALL be discarded, leaving memory unchanged.

Configuration
REQ-028 Macro DMEM_ERR_CHECK_EN SHALL, when defined, assert Err_o in DONE for any of these: misaligned half word (Addr[0]=1); misaligned word (Addr[1:0]!=0); both codes nonzero; word index >= DEPTH_WORDS.
REQ-029 When DMEM_ERR_CHECK_EN is defined, an erroneous request SHALL perform no memory access.
REQ-030 When DMEM_ERR_CHECK_EN is undefined, Err_o SHALL be tied 0.
REQ-031 When DMEM_ERR_CHECK_EN is undefined, misaligned addresses SHALL be aligned down, the index SHALL wrap modulo DEPTH_WORDS, and write SHALL take priority if both codes are nonzero.

Verification (WAIT_CYCLES=2)
REQ-032 Word write 0xDEADBEEF @0x10, then word read @0x10 -> Stall_o high 3 cycles each; second Done_o shows ReadData_o=0xDEADBEEF, Err_o=0.
REQ-033 Byte write 0x000000AA @0x13, then word read @0x10 -> 0xAAADBEEF; half read @0x12 -> 0x0000AAAD; byte read @0x11 -> 0x000000BE.
REQ-034 With the macro defined, word read @0x12 -> Stall_o 1 cycle, then Done_o=1, Err_o=1, ReadData_o=0, memory unchanged; with the macro undefined -> returns word @0x10, Err_o=0.
REQ-035 Word write 0x12345678 @0x20 with rst_i pulsed during WAIT -> outputs 0 asynchronously, FSM in IDLE, subsequent read @0x20 returns the prior value.
REQ-036 Codes held in the DONE cycle -> not re-accepted (single Done_o); code 0/0 for 5 cycles -> Stall_o=0, Done_o=0 throughout.
